// File: rtl/pipeline_step_controller_pkg.sv
// Shared definitions for the pipeline step controller: state and command encodings,
// the per-stage control bundle and a small state-decode helper.
package pipeline_step_controller_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRun    = 3'd1;
  localparam logic [2:0] StStep   = 3'd2;
  localparam logic [2:0] StDrain  = 3'd3;
  localparam logic [2:0] StHalted = 3'd4;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  localparam int unsigned N_DRAIN_DEFAULT = 3;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
    logic if_id_flush;
    logic id_ex_flush;
  } stage_ctl_t;

  // States in which the pipeline advances by one step per clock.
  function automatic logic is_adv(input logic [2:0] st);
    return (st == StRun) || (st == StStep) || (st == StDrain);
  endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Combinational load-use detector: a load in EX whose destination feeds the instruction in ID.
module hazard_detect_unit #(
  parameter int unsigned NB_REG = 5
) (
  input  logic              i_ex_mem_read,
  input  logic [NB_REG-1:0] i_ex_rt,
  input  logic [NB_REG-1:0] i_id_rs,
  input  logic [NB_REG-1:0] i_id_rt,
  input  logic              i_id_uses_rt,
  output logic              o_load_use
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match   = (i_ex_rt == i_id_rs);
    rt_match   = i_id_uses_rt && (i_ex_rt == i_id_rt);
    // Register zero is hard-wired, so a load into it never creates a dependency.
    o_load_use = i_ex_mem_read && (i_ex_rt != '0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_step_controller.sv
// Central sequencer for the 5-stage pipeline: turns debug commands into per-stage enables,
// inserts load-use bubbles, flushes on taken branches and drains the pipe after HALT.
module pipeline_step_controller
  import pipeline_step_controller_pkg::*;
#(
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned NB_CNT  = 32,
  parameter int unsigned N_DRAIN = N_DRAIN_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd,
  output logic              o_cmd_ready,
  input  logic [NB_REG-1:0] i_id_rs,
  input  logic [NB_REG-1:0] i_id_rt,
  input  logic              i_id_uses_rt,
  input  logic              i_id_halt,
  input  logic              i_ex_mem_read,
  input  logic [NB_REG-1:0] i_ex_rt,
  input  logic              i_ex_branch_taken,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_id_ex_en,
  output logic              o_ex_mem_en,
  output logic              o_mem_wb_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_flush,
  output logic [2:0]        o_state,
  output logic              o_halted,
  output logic              o_step_done,
  output logic [NB_CNT-1:0] o_cycle_count
);

  localparam int unsigned NB_DRAIN = (N_DRAIN > 1) ? $clog2(N_DRAIN) : 1;

  logic [2:0]          state_q, state_d;
  logic [NB_DRAIN-1:0] drain_cnt_q, drain_cnt_d;
  logic [NB_CNT-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic                step_done_q, step_done_d;

  logic       adv;
  logic       load_use;
  logic       halt_go;
  logic       cmd_acc;
  stage_ctl_t ctl;

  hazard_detect_unit #(
    .NB_REG(NB_REG)
  ) u_hazard_detect_unit (
    .i_ex_mem_read(i_ex_mem_read),
    .i_ex_rt      (i_ex_rt),
    .i_id_rs      (i_id_rs),
    .i_id_rt      (i_id_rt),
    .i_id_uses_rt (i_id_uses_rt),
    .o_load_use   (load_use)
  );

  always_comb begin
    adv         = is_adv(state_q);
    o_cmd_ready = (state_q == StIdle) || (state_q == StRun);
    cmd_acc     = i_cmd_valid && o_cmd_ready;
    // A HALT in ID only retires when it actually moves on: not squashed, not stalled.
    halt_go     = ((state_q == StRun) || (state_q == StStep)) && i_id_halt &&
                  !i_ex_branch_taken && !load_use;
  end

  // Stage enables and flushes; hazard inputs are ignored while draining.
  always_comb begin
    ctl = '0;
    if (state_q == StDrain) begin
      ctl.id_ex       = 1'b1;
      ctl.ex_mem      = 1'b1;
      ctl.mem_wb      = 1'b1;
      ctl.id_ex_flush = 1'b1;
    end else if (adv) begin
      if (i_ex_branch_taken) begin
        ctl = '1;
      end else if (load_use) begin
        ctl.id_ex       = 1'b1;
        ctl.ex_mem      = 1'b1;
        ctl.mem_wb      = 1'b1;
        ctl.id_ex_flush = 1'b1;
      end else if (i_id_halt) begin
        ctl.id_ex  = 1'b1;
        ctl.ex_mem = 1'b1;
        ctl.mem_wb = 1'b1;
      end else begin
        ctl.pc     = 1'b1;
        ctl.if_id  = 1'b1;
        ctl.id_ex  = 1'b1;
        ctl.ex_mem = 1'b1;
        ctl.mem_wb = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    step_done_d = 1'b0;
    cycle_cnt_d = cycle_cnt_q;

    if (adv && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + NB_CNT'(1);
    end

    case (state_q)
      StIdle: begin
        if (cmd_acc && (i_cmd == CMD_RUN)) begin
          state_d = StRun;
        end else if (cmd_acc && (i_cmd == CMD_STEP)) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (halt_go) begin
          state_d     = StDrain;
          drain_cnt_d = NB_DRAIN'(N_DRAIN - 1);
        end else if (cmd_acc && (i_cmd == CMD_STOP)) begin
          state_d = StIdle;
        end
      end
      StStep: begin
        if (halt_go) begin
          state_d     = StDrain;
          drain_cnt_d = NB_DRAIN'(N_DRAIN - 1);
        end else begin
          state_d     = StIdle;
          step_done_d = 1'b1;
        end
      end
      StDrain: begin
        if (drain_cnt_q == '0) begin
          state_d = StHalted;
        end else begin
          drain_cnt_d = drain_cnt_q - NB_DRAIN'(1);
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
      cycle_cnt_q <= '0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      step_done_q <= step_done_d;
    end
  end

  always_comb begin
    o_pc_en       = ctl.pc;
    o_if_id_en    = ctl.if_id;
    o_id_ex_en    = ctl.id_ex;
    o_ex_mem_en   = ctl.ex_mem;
    o_mem_wb_en   = ctl.mem_wb;
    o_if_id_flush = ctl.if_id_flush;
    o_id_ex_flush = ctl.id_ex_flush;
    o_state       = state_q;
    o_halted      = (state_q == StHalted);
    o_step_done   = step_done_q;
    o_cycle_count = cycle_cnt_q;
  end

endmodule

// File: tb/tb_pipeline_step_controller.sv
// Scoreboard bench for pipeline_step_controller: a behavioural model predicts each cycle's
// outputs into a queue, and a negedge monitor pops and compares.
module tb_pipeline_step_controller;

  localparam int NB_REG = 5;
  localparam int NB_CNT = 32;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_STEP   = 2;
  localparam int M_DRAIN  = 3;
  localparam int M_HALTED = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic [1:0]        cmd;
  logic              cmd_ready;
  logic [NB_REG-1:0] id_rs, id_rt, ex_rt;
  logic              id_uses_rt, id_halt, ex_mem_read, ex_br;
  logic              pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic              if_id_flush, id_ex_flush;
  logic [2:0]        state;
  logic              halted, step_done;
  logic [NB_CNT-1:0] cycle_count;

  always #5 clk = ~clk;

  pipeline_step_controller #(
    .NB_REG (NB_REG),
    .NB_CNT (NB_CNT),
    .N_DRAIN(3)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_cmd_valid      (cmd_valid),
    .i_cmd            (cmd),
    .o_cmd_ready      (cmd_ready),
    .i_id_rs          (id_rs),
    .i_id_rt          (id_rt),
    .i_id_uses_rt     (id_uses_rt),
    .i_id_halt        (id_halt),
    .i_ex_mem_read    (ex_mem_read),
    .i_ex_rt          (ex_rt),
    .i_ex_branch_taken(ex_br),
    .o_pc_en          (pc_en),
    .o_if_id_en       (if_id_en),
    .o_id_ex_en       (id_ex_en),
    .o_ex_mem_en      (ex_mem_en),
    .o_mem_wb_en      (mem_wb_en),
    .o_if_id_flush    (if_id_flush),
    .o_id_ex_flush    (id_ex_flush),
    .o_state          (state),
    .o_halted         (halted),
    .o_step_done      (step_done),
    .o_cycle_count    (cycle_count)
  );

  typedef struct packed {
    logic       r, v;
    logic [1:0] c;
    logic [4:0] rs, rt;
    logic       ur, h, mr;
    logic [4:0] ert;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic [6:0]  ctl;   // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    logic [2:0]  st;
    logic        halted;
    logic        done;
    logic        ready;
    logic [31:0] cnt;
  } exp_t;

  exp_t   q[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  int     m_mode  = M_IDLE;
  int     m_drain = 0;
  int     m_done  = 0;
  longint m_cnt   = 0;

  stim_t  s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic stim_t nop();
    stim_t z;
    z = '0;
    return z;
  endfunction

  // Predict this cycle's outputs from the model, then advance the model across the next edge.
  task automatic model_cycle(input stim_t t);
    exp_t e;
    bit   adv, lu, halt_go;
    adv = (m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN);
    lu  = t.mr && (t.ert != 0) && ((t.ert == t.rs) || (t.ur && (t.ert == t.rt)));
    e = '0;
    if (m_mode == M_DRAIN)  e.ctl = 7'b0011101;
    else if (!adv)          e.ctl = 7'b0000000;
    else if (t.br)          e.ctl = 7'b1111111;
    else if (lu)            e.ctl = 7'b0011101;
    else if (t.h)           e.ctl = 7'b0011100;
    else                    e.ctl = 7'b1111100;
    e.st     = 3'(m_mode);
    e.halted = (m_mode == M_HALTED);
    e.done   = (m_done != 0);
    e.ready  = (m_mode == M_IDLE) || (m_mode == M_RUN);
    e.cnt    = 32'(m_cnt);
    q.push_back(e);

    halt_go = ((m_mode == M_RUN) || (m_mode == M_STEP)) && t.h && !t.br && !lu;
    if (t.r) begin
      m_mode = M_IDLE; m_drain = 0; m_done = 0; m_cnt = 0;
    end else begin
      if (adv && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      m_done = 0;
      case (m_mode)
        M_IDLE: if (t.v && t.c == 2'b01) m_mode = M_RUN;
                else if (t.v && t.c == 2'b10) m_mode = M_STEP;
        M_RUN: if (halt_go) begin m_mode = M_DRAIN; m_drain = 3; end
               else if (t.v && t.c == 2'b11) m_mode = M_IDLE;
        M_STEP: if (halt_go) begin m_mode = M_DRAIN; m_drain = 3; end
                else begin m_mode = M_IDLE; m_done = 1; end
        M_DRAIN: begin
          m_drain--;
          if (m_drain == 0) m_mode = M_HALTED;
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick(input stim_t t);
    @(posedge clk);
    #1;
    rst = t.r; cmd_valid = t.v; cmd = t.c; id_rs = t.rs; id_rt = t.rt;
    id_uses_rt = t.ur; id_halt = t.h; ex_mem_read = t.mr; ex_rt = t.ert; ex_br = t.br;
    model_cycle(t);
  endtask

  task automatic do_cmd(input logic [1:0] c);
    stim_t t;
    t = nop(); t.v = 1'b1; t.c = c;
    tick(t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(nop());
  endtask

  task automatic do_reset();
    stim_t t;
    t = nop(); t.r = 1'b1;
    tick(t);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest prediction.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stage_ctl", 64'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                              if_id_flush, id_ex_flush}), 64'(e.ctl));
        chk("state_flags", 64'({state, halted, step_done, cmd_ready}),
            64'({e.st, e.halted, e.done, e.ready}));
        chk("cycle_count", 64'(cycle_count), 64'(e.cnt));
      end
    end
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; id_rs = '0; id_rt = '0;
    id_uses_rt = 1'b0; id_halt = 1'b0; ex_mem_read = 1'b0; ex_rt = '0; ex_br = 1'b0;

    do_reset();
    do_reset();
    idle(2);

    // Three single steps, each followed by a done pulse.
    for (int i = 0; i < 3; i++) begin
      do_cmd(2'b10);
      idle(3);
    end

    // Load-use stall, then the non-stalling variants.
    do_cmd(2'b01);
    idle(2);
    s = nop(); s.mr = 1; s.ert = 5; s.rs = 5; tick(s);
    idle(1);
    s = nop(); s.mr = 1; s.ert = 0; s.rs = 0; tick(s);
    s = nop(); s.mr = 1; s.ert = 5; s.rt = 5; s.rs = 1; s.ur = 0; tick(s);
    s = nop(); s.mr = 1; s.ert = 5; s.rt = 5; s.rs = 1; s.ur = 1; tick(s);

    // Branch dominates load-use and squashes a HALT.
    s = nop(); s.br = 1; s.mr = 1; s.ert = 7; s.rs = 7; tick(s);
    s = nop(); s.br = 1; s.h = 1; tick(s);
    idle(2);

    // HALT drains three cycles then parks; commands are refused.
    s = nop(); s.h = 1; tick(s);
    s = nop(); s.br = 1; s.mr = 1; s.ert = 3; s.rs = 3; tick(s);
    idle(3);
    do_cmd(2'b01);
    do_cmd(2'b10);
    idle(1);

    // Reset mid-drain, then STOP in IDLE does nothing.
    do_reset();
    do_cmd(2'b01);
    idle(10);
    s = nop(); s.h = 1; tick(s);
    idle(1);
    do_reset();
    do_cmd(2'b11);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      s.r  = ($urandom_range(0, 99) == 0);
      s.v  = ($urandom_range(0, 2) == 0);
      s.c  = 2'($urandom_range(0, 3));
      s.rs = 5'($urandom_range(0, 3));
      s.rt = 5'($urandom_range(0, 3));
      s.ert = 5'($urandom_range(0, 3));
      s.ur = 1'($urandom_range(0, 1));
      s.mr = 1'($urandom_range(0, 1));
      s.h  = ($urandom_range(0, 15) == 0);
      s.br = ($urandom_range(0, 7) == 0);
      tick(s);
    end

    tick(nop());
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
